// File: rtl/alu_dsp_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_dsp_arbiter_pkg
//   Shared definitions for the ALU DSP slice and its schedulers:
//   operand widths, DSP op encodings and the arbiter state type.
// -----------------------------------------------------------------------------
package alu_dsp_arbiter_pkg;

   // Operand / result widths of the dual-channel DSP slice
   localparam int ALU_DSP_OPW = 9;
   localparam int ALU_DSP_ABW = 18;
   localparam int ALU_DSP_CW  = 48;

   // DSP op encodings. NOP is all-zero so an idle mux output is simply 0.
   localparam logic [ALU_DSP_OPW-1:0] ALU_DSP_NOP      = 9'h000;
   localparam logic [ALU_DSP_OPW-1:0] ALU_DSP_XIN_MULT = 9'h005;
   localparam logic [ALU_DSP_OPW-1:0] ALU_DSP_ZIN_MULT = 9'h025;
   localparam logic [ALU_DSP_OPW-1:0] ALU_DSP_ZIN_ADD  = 9'h033;

   // Arbiter ownership state; also exported on the debug port
   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/alu_dsp_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// alu_rr_pick
//   Combinational round-robin picker. Returns the first set bit of req_i
//   searching start_i, start_i+1, ... and wrapping modulo N.
//
//   req_i    in   N     request vector
//   start_i  in   IDW   first index to consider (must be < N)
//   found_o  out  1     some request is set
//   id_o     out  IDW   index of the chosen request, 0 when none
// -----------------------------------------------------------------------------
module alu_rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 3
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] start_i,
   output logic           found_o,
   output logic [IDW-1:0] id_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IDW-1:0] pos;
   logic [IDW:0]   sum;

   // Rotate so that start_i lands on bit 0; the lowest set bit of rot is
   // then the round-robin winner, expressed as a distance from start_i.
   assign dbl = {req_i, req_i};
   assign rot = N'(dbl >> start_i);

   always_comb begin
      found_o = 1'b0;
      pos     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found_o = 1'b1;
            pos     = IDW'(i);
         end
      end
      sum = {1'b0, start_i} + {1'b0, pos};
      if (sum >= (IDW+1)'(N)) begin
         sum = sum - (IDW+1)'(N);
      end
      id_o = found_o ? sum[IDW-1:0] : '0;
   end

endmodule

// File: rtl/alu_dsp_arbiter.sv
// -----------------------------------------------------------------------------
// alu_dsp_arbiter
//   Shares one dual-channel ALU DSP slice between NUM_REQ clients with
//   round-robin arbitration and burst lock, and returns a per-client
//   result-valid strobe aligned with the DSP P outputs.
//
//   Handshake: a client holds req[k] to ask for the DSP. Once grant[k] is
//   seen, every cycle with req[k] & grant[k] presents exactly one op to the
//   DSP. Dropping req[k] releases the DSP at that clock edge.
//
//   clk        in   1              system clock
//   reset      in   1              asynchronous reset, active low
//   req        in   NUM_REQ        request / lock per client
//   grant      out  NUM_REQ        one-hot registered grant
//   req_op     in   NUM_REQ*9      per-client op, client k at [9k+8:9k]
//   req_al/bl/ar/br in NUM_REQ*18  per-client A/B operands
//   req_cl/cr  in   NUM_REQ*48     per-client C operands
//   dsp_op     out  9              op to DSP (NOP when nobody issues)
//   dsp_al/bl/ar/br out 18         operands to DSP
//   dsp_cl/cr  out  48             operands to DSP
//   dsp_pl/pr  in   48             DSP results
//   res_pl/pr  out  48             DSP results passed through
//   res_valid  out  NUM_REQ        one-hot: P holds client k's result
//   res_id     out  IDW            issuer of the current result, 0 if none
//   busy       out  1              grant held or op in flight
//   dbg_state  out  1              arbiter state (0 idle, 1 owned)
//
//   DSP_LAT must be at least 2.
// -----------------------------------------------------------------------------
module alu_dsp_arbiter
   import alu_dsp_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DSP_LAT = 3,
   parameter int IDW     = 3
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req,
   output logic [NUM_REQ-1:0]              grant,
   input  logic [NUM_REQ*ALU_DSP_OPW-1:0]  req_op,
   input  logic [NUM_REQ*ALU_DSP_ABW-1:0]  req_al,
   input  logic [NUM_REQ*ALU_DSP_ABW-1:0]  req_bl,
   input  logic [NUM_REQ*ALU_DSP_ABW-1:0]  req_ar,
   input  logic [NUM_REQ*ALU_DSP_ABW-1:0]  req_br,
   input  logic [NUM_REQ*ALU_DSP_CW-1:0]   req_cl,
   input  logic [NUM_REQ*ALU_DSP_CW-1:0]   req_cr,
   output logic [ALU_DSP_OPW-1:0]          dsp_op,
   output logic [ALU_DSP_ABW-1:0]          dsp_al,
   output logic [ALU_DSP_ABW-1:0]          dsp_bl,
   output logic [ALU_DSP_ABW-1:0]          dsp_ar,
   output logic [ALU_DSP_ABW-1:0]          dsp_br,
   output logic [ALU_DSP_CW-1:0]           dsp_cl,
   output logic [ALU_DSP_CW-1:0]           dsp_cr,
   input  logic [ALU_DSP_CW-1:0]           dsp_pl,
   input  logic [ALU_DSP_CW-1:0]           dsp_pr,
   output logic [ALU_DSP_CW-1:0]           res_pl,
   output logic [ALU_DSP_CW-1:0]           res_pr,
   output logic [NUM_REQ-1:0]              res_valid,
   output logic [IDW-1:0]                  res_id,
   output logic                            busy,
   output logic                            dbg_state
);

   // The result register is the last stage, so DSP_LAT-1 tag stages precede it
   localparam int PIPE = DSP_LAT - 1;

   arb_state_e          state_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [NUM_REQ-1:0]  grant_d;
   logic [IDW-1:0]      owner_q;
   logic [IDW-1:0]      last_q;
   logic [IDW-1:0]      base;
   logic [IDW-1:0]      start_idx;
   logic                pick_found;
   logic [IDW-1:0]      pick_id;
   logic                issue;

   logic [PIPE-1:0]     pipe_v_q;
   logic [IDW-1:0]      pipe_id_q [PIPE];
   logic [NUM_REQ-1:0]  tail_onehot;
   logic [NUM_REQ-1:0]  res_valid_q;
   logic [IDW-1:0]      res_id_q;

   // grant is one-hot at owner_q, so this is req[owner] & grant[owner]
   assign issue = |(grant_q & req);

   // ---------------------------------------------------------------------
   // Round-robin search: from last+1 when idle, from owner+1 on release.
   // On release req[owner] is already low, so the owner is never re-picked.
   // ---------------------------------------------------------------------
   always_comb begin
      base      = (state_q == ARB_IDLE) ? last_q : owner_q;
      start_idx = (base == IDW'(NUM_REQ - 1)) ? '0 : base + IDW'(1);
   end

   alu_rr_pick #(
      .N   (NUM_REQ),
      .IDW (IDW)
   ) u_pick (
      .req_i   (req),
      .start_i (start_idx),
      .found_o (pick_found),
      .id_o    (pick_id)
   );

   always_comb begin
      grant_d = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         grant_d[k] = (pick_id == IDW'(k));
      end
   end

   // ---------------------------------------------------------------------
   // Ownership FSM with burst lock: the owner keeps the DSP for as long as
   // it holds req; handover happens on the release edge with no dead cycle.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         last_q  <= IDW'(NUM_REQ - 1);
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_found) begin
                  state_q <= ARB_OWNED;
                  grant_q <= grant_d;
                  owner_q <= pick_id;
               end
            end
            ARB_OWNED: begin
               if (!issue) begin
                  last_q <= owner_q;
                  if (pick_found) begin
                     grant_q <= grant_d;
                     owner_q <= pick_id;
                  end else begin
                     state_q <= ARB_IDLE;
                     grant_q <= '0;
                     owner_q <= '0;
                  end
               end
            end
            default: begin
               state_q <= ARB_IDLE;
               grant_q <= '0;
               owner_q <= '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Operand mux: only the issuing client reaches the DSP; otherwise NOP
   // with zero operands.
   // ---------------------------------------------------------------------
   always_comb begin
      dsp_op = ALU_DSP_NOP;
      dsp_al = '0;
      dsp_bl = '0;
      dsp_ar = '0;
      dsp_br = '0;
      dsp_cl = '0;
      dsp_cr = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_q[k] && req[k]) begin
            dsp_op = req_op[k*ALU_DSP_OPW +: ALU_DSP_OPW];
            dsp_al = req_al[k*ALU_DSP_ABW +: ALU_DSP_ABW];
            dsp_bl = req_bl[k*ALU_DSP_ABW +: ALU_DSP_ABW];
            dsp_ar = req_ar[k*ALU_DSP_ABW +: ALU_DSP_ABW];
            dsp_br = req_br[k*ALU_DSP_ABW +: ALU_DSP_ABW];
            dsp_cl = req_cl[k*ALU_DSP_CW +: ALU_DSP_CW];
            dsp_cr = req_cr[k*ALU_DSP_CW +: ALU_DSP_CW];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Tag pipeline: {issue, owner} travels alongside the op so that results
   // of a released owner still drain to the right client after handover.
   // ---------------------------------------------------------------------
   always_comb begin
      tail_onehot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         tail_onehot[k] = pipe_v_q[PIPE-1] && (pipe_id_q[PIPE-1] == IDW'(k));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_v_q    <= '0;
         for (int i = 0; i < PIPE; i++) begin
            pipe_id_q[i] <= '0;
         end
         res_valid_q <= '0;
         res_id_q    <= '0;
      end else begin
         pipe_v_q[0]  <= issue;
         pipe_id_q[0] <= issue ? owner_q : '0;
         for (int i = 1; i < PIPE; i++) begin
            pipe_v_q[i]  <= pipe_v_q[i-1];
            pipe_id_q[i] <= pipe_id_q[i-1];
         end
         res_valid_q <= tail_onehot;
         res_id_q    <= pipe_v_q[PIPE-1] ? pipe_id_q[PIPE-1] : '0;
      end
   end

   assign grant     = grant_q;
   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_pl    = dsp_pl;
   assign res_pr    = dsp_pr;
   assign busy      = (|grant_q) | (|pipe_v_q);
   assign dbg_state = (state_q == ARB_OWNED);

endmodule
